// File: rtl/cond_cov_pkg.sv
// Shared branch codes and FSM encoding for the conditional-branch coverage monitor.
package cond_cov_pkg;

  localparam logic [1:0] BR_LT   = 2'd0;
  localparam logic [1:0] BR_GT   = 2'd1;
  localparam logic [1:0] BR_EQ   = 2'd2;
  localparam logic [1:0] BR_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Maps a branch code onto its covered-flag bit; NONE maps to no bit.
  function automatic logic [2:0] br_onehot(logic [1:0] br);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (br)
      BR_LT:   oh = 3'b001;
      BR_GT:   oh = 3'b010;
      BR_EQ:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear, async active-high reset.
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cond_branch_monitor.sv
// Counts which arm of a = (y<z) ? b : (y>z) ? c : d was taken and flags full branch coverage.
module cond_branch_monitor
  import cond_cov_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          sample_en,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] z,
  input  logic [1:0]    a,
  output logic [CW-1:0] hit_lt,
  output logic [CW-1:0] hit_gt,
  output logic [CW-1:0] hit_eq,
  output logic [CW-1:0] trans_cnt,
  output logic [2:0]    covered,
  output logic [1:0]    last_a,
  output logic [1:0]    last_br,
  output logic          all_covered
);

  logic       do_sample;
  logic [1:0] br;
  logic [2:0] covered_q, covered_d;
  logic [1:0] last_a_q, last_br_q;
  logic       inc_trans;
  state_t     state_q, state_d;

  // A clear in the same cycle discards the sample.
  assign do_sample = sample_en & ~clear;

  always_comb begin
    br = BR_EQ;
    if (y < z) begin
      br = BR_LT;
    end else if (y > z) begin
      br = BR_GT;
    end
  end

  assign inc_trans = do_sample && (last_br_q != BR_NONE) && (br != last_br_q);

  sat_counter #(.CW(CW)) u_hit_lt (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (do_sample && (br == BR_LT)),
    .cnt   (hit_lt)
  );

  sat_counter #(.CW(CW)) u_hit_gt (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (do_sample && (br == BR_GT)),
    .cnt   (hit_gt)
  );

  sat_counter #(.CW(CW)) u_hit_eq (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (do_sample && (br == BR_EQ)),
    .cnt   (hit_eq)
  );

  sat_counter #(.CW(CW)) u_trans (
    .clock (clock),
    .reset (reset),
    .clr   (clear),
    .inc   (inc_trans),
    .cnt   (trans_cnt)
  );

  always_comb begin
    covered_d = covered_q;
    if (clear) begin
      covered_d = 3'b000;
    end else if (do_sample) begin
      covered_d = covered_q | br_onehot(br);
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (do_sample) begin
      unique case (state_q)
        ST_IDLE, ST_COLLECT: state_d = (covered_d == 3'b111) ? ST_DONE : ST_COLLECT;
        ST_DONE:             state_d = ST_DONE;
        default:             state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered_q <= 3'b000;
      last_a_q  <= 2'd0;
      last_br_q <= BR_NONE;
      state_q   <= ST_IDLE;
    end else begin
      covered_q <= covered_d;
      state_q   <= state_d;
      if (clear) begin
        last_a_q  <= 2'd0;
        last_br_q <= BR_NONE;
      end else if (do_sample) begin
        last_a_q  <= a;
        last_br_q <= br;
      end
    end
  end

  assign covered     = covered_q;
  assign last_a      = last_a_q;
  assign last_br     = last_br_q;
  assign all_covered = (state_q == ST_DONE);

endmodule

// File: doc/cond_branch_monitor.md
# cond_branch_monitor

Sequential coverage monitor placed directly downstream of the nested-conditional datapath `a = (y < z) ? b : (y > z) ? c : d`. On each enabled sample it classifies which branch produced `a` by comparing `y` and `z`. It keeps saturating per-branch hit counters, sticky covered flags, a branch-transition counter and the last captured `a`. An FSM reports when all three branches have been exercised. Diagnostics use it to cross-check the coverage tool's conditional-subexpression results against hardware-counted ground truth.

## Interface
- `CW`, default 8: width of hit and transition counters.
- `DW`, default 4: width of `y` and `z`.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous clear of all statistics.
- `sample_en`  in  1: sample `y`, `z` and `a` this cycle.
- `y`  in  DW: left compare operand.
- `z`  in  DW: right compare operand.
- `a`  in  2: conditional result being monitored.
- `hit_lt`  out  CW: samples with y<z (branch b).
- `hit_gt`  out  CW: samples with y>z (branch c).
- `hit_eq`  out  CW: samples with y==z (branch d).
- `trans_cnt`  out  CW: samples whose branch differs from the previous sampled branch.
- `covered`  out  3: sticky flags, bit0 LT, bit1 GT, bit2 EQ.
- `last_a`  out  2: `a` captured at the most recent sample.
- `last_br`  out  2: branch code of the most recent sample.
- `all_covered`  out  1: high in state DONE.

## Operation
- Branch code: LT=0, GT=1, EQ=2, NONE=3. Compares are unsigned over DW bits.
- Sample (`sample_en`=1, `clear`=0):
  - Increment the matching hit counter, saturating at 2^CW−1 with no wrap.
  - Set the matching `covered` bit.
  - Capture `last_a` and `last_br`.
- Transitions: if `last_br`≠NONE and the new branch ≠ `last_br`, increment `trans_cnt` (saturating). The first sample after reset or clear never counts as a transition.
- FSM states:
  - IDLE: no sample since reset or clear.
  - COLLECT: at least one sample taken, fewer than 3 branches covered.
  - DONE: `covered`==3'b111. Sticky until clear or reset.
- FSM transitions:
  - IDLE→COLLECT on first sample.
  - IDLE or COLLECT→DONE when the updated `covered` becomes 111; a single sample may not skip COLLECT unless already 2 bits set.
  - Any state→IDLE on `clear`.
- `clear` has priority over `sample_en` in the same cycle: the sample is discarded.
- Reset values: all counters 0, `covered`=0, `last_a`=0, `last_br`=NONE, state IDLE, `all_covered`=0.
- Reset asserted mid-sampling forces reset values immediately, independent of `clock`.

## Timing
- All outputs are registered. A sample at edge N is visible after edge N; `all_covered` rises in the same cycle as the third `covered` bit.
- No combinational path from inputs to outputs.
- Back-to-back samples every cycle are supported with no bubbles.
- When `sample_en`=0, all state holds.
- A saturated counter holds at max while the other counters keep counting.

## Structure
- Package `cond_cov_pkg` holds:
  - branch code constants BR_LT, BR_GT, BR_EQ, BR_NONE (2 bits);
  - FSM state encoding ST_IDLE, ST_COLLECT, ST_DONE.
- Sub-module `sat_counter` (parameter CW; ports `clock`, `reset`, `clr`, `inc`, `cnt`) is instantiated four times: three hit counters and one transition counter.
- Classification, capture registers and the FSM live in the top module.

## Test plan
- Reset, then y=3,z=5,a=0 sampled, then y=5,z=5,a=2 sampled:
  - hit_lt=1, hit_eq=1, hit_gt=0;
  - covered=101, trans_cnt=1, last_a=2, state COLLECT.
- Add sample y=9,z=2,a=1 → hit_gt=1, covered=111, all_covered=1 in the same cycle, trans_cnt=2.
- CW=2, 5 consecutive LT samples → hit_lt=3 (saturated), trans_cnt=0, other counters 0.
- clear and sample_en both high with y<z → all stats 0, last_br=NONE, state IDLE, sample not counted.
- Assert reset asynchronously between edges while in DONE → all outputs reach reset values before the next edge.
- sample_en low for 10 cycles with y and z toggling → all outputs unchanged.
